inv_mix_columns_iter: RTL and testbench
=======================================

Name: inv_mix_columns_iter

Overview:
- Iterative AES InvMixColumns engine for the decryption datapath. It is the inverse of the encrypt-side combinational MixColumns.
- Accepts one 128-bit state through a valid/ready handshake. Transforms COLS_PER_CYCLE columns per clock and returns the result through a valid/ready handshake.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the round-iterative decryptor. It trades latency for area.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per BUSY cycle. Legal values are 1, 2 and 4. Elaboration fails for any other value.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data is valid
- in_ready  out  1  block can accept a state
- in_data  in  128  AES state; column c = in_data[127-32c -: 32], row r of column = byte [31-8r -: 8] within column
- out_valid  out  1  out_data holds a finished result
- out_ready  in  1  downstream accepts out_data
- out_data  out  128  InvMixColumns(in_data), same byte layout
- busy  out  1  high in BUSY and DONE

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, col_cnt=0, working register=0, out_data=0, out_valid=0, busy=0, in_ready=1.
  - An in-flight state is discarded; nothing partial is emitted.
- States: IDLE, BUSY, DONE. in_ready = (state==IDLE), purely registered-state decode.
- IDLE: if in_valid at an edge, latch in_data into the working register, col_cnt<=0, go to BUSY. Otherwise stay.
- BUSY: each edge replaces columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 of the working register with their transform.
  - col_cnt advances by COLS_PER_CYCLE.
  - After the last group (N=4/COLS_PER_CYCLE edges), copy the full result into out_data, set out_valid=1, go to DONE.
  - in_valid during BUSY is ignored and not queued.
- DONE: out_valid=1, and out_data is held stable until the handshake completes. When out_valid && out_ready at an edge: out_valid<=0, go to IDLE. out_data keeps its last value.
- Latency:
  - Accept edge at t gives out_valid high after edge t+N (N=4, 2 or 1).
  - Minimum initiation interval is N+2 cycles: accept, N BUSY edges, DONE handshake.
- Column transform, all arithmetic in GF(2^8) mod x^8+x^4+x^3+x+1 (reduction 8'h1b). For column bytes a0..a3:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
  - Build the multiplications from the xtime chain: x2=xtime(a), x4=xtime(x2), x8=xtime(x4).
  - Then 09=x8^a, 0b=x8^x2^a, 0d=x8^x4^a, 0e=x8^x4^x2.
  - xtime(a) = {a[6:0],0} ^ (a[7] ? 8'h1b : 0).
- All datapath widths are 8 bits. No carries; XOR only.
- Columns not yet processed stay untouched in the working register.
- out_data never shows an intermediate working value.

Decomposition:
- Shared package aes_pkg:
  - AES_POLY_RED = 8'h1b
  - inverse coefficient constants 8'h0e, 8'h0b, 8'h0d, 8'h09
  - xtime function
  - state/column/byte typedefs (word128, word32, byte8)
  - FSM state enum {IDLE, BUSY, DONE}
- One combinational sub-module inv_mix_single_column (32-bit in, 32-bit out), instantiated COLS_PER_CYCLE times.
- The top level owns the FSM, col_cnt, working register and handshakes.

Test Plan:
- Single column vectors (COLS_PER_CYCLE=1): in_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> out_data = db135345_f20a225c_01010101_c6c6c6c6. out_valid rises exactly 4 cycles after the accept edge.
- Round trip, all COLS_PER_CYCLE values: in_data = d5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d -> out_data = d4d4d4d5_2d26314c_db135345_f20a225c. Latency is 4, 2 and 1 cycles respectively.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - out_valid and out_data stay stable and in_ready stays 0.
  - Pulse in_valid with other data during this window -> it is ignored.
  - Raising out_ready -> IDLE next edge.
- Back-to-back: in_valid held high with two states and out_ready=1 -> both results are correct and in order, with the second accept occurring N+2 cycles after the first.
- Reset mid-BUSY: assert rst after 2 of 4 columns -> immediately out_valid=0, out_data=0, in_ready=1. A following vector then produces the correct result.
- Random: 1000 random states checked against a reference model, including the all-zero state (0 -> 0) and all-ff state (ff..ff -> ff..ff).

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES GF(2^8) helpers, datapath typedefs and iterative-engine FSM states
package aes_pkg;
  typedef logic [127:0] word128;
  typedef logic [31:0] word32;
  typedef logic [7:0] byte8;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam byte8 AES_POLY_RED = 8'h1b;
  localparam byte8 INV_0E = 8'h0e;
  localparam byte8 INV_0B = 8'h0b;
  localparam byte8 INV_0D = 8'h0d;
  localparam byte8 INV_09 = 8'h09;
  function automatic byte8 xtime(byte8 a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY_RED : 8'h00);
  endfunction
  // k is always a constant at the call site, so only one XOR term survives
  function automatic byte8 inv_mul(byte8 a, byte8 k);
    byte8 x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return k == INV_09 ? x8 ^ a :
           k == INV_0B ? x8 ^ x2 ^ a :
           k == INV_0D ? x8 ^ x4 ^ a : x8 ^ x4 ^ x2;
  endfunction
endpackage

// File: rtl/inv_mix_columns_iter_col.sv
// inv_mix_single_column: combinational InvMixColumns of one 32-bit column
module inv_mix_single_column
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] res
);
  byte8 a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col;
  assign res = {
    inv_mul(a0, INV_0E) ^ inv_mul(a1, INV_0B) ^ inv_mul(a2, INV_0D) ^ inv_mul(a3, INV_09),
    inv_mul(a0, INV_09) ^ inv_mul(a1, INV_0E) ^ inv_mul(a2, INV_0B) ^ inv_mul(a3, INV_0D),
    inv_mul(a0, INV_0D) ^ inv_mul(a1, INV_09) ^ inv_mul(a2, INV_0E) ^ inv_mul(a3, INV_0B),
    inv_mul(a0, INV_0B) ^ inv_mul(a1, INV_0D) ^ inv_mul(a2, INV_09) ^ inv_mul(a3, INV_0E)
  };
endmodule

// File: rtl/inv_mix_columns_iter.sv
// inv_mix_columns_iter: iterative AES InvMixColumns, COLS_PER_CYCLE columns per busy cycle
module inv_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);
  state_t state, state_nx;
  logic [1:0] col_cnt;
  word128 work, work_nx;
  word32 col_res [COLS_PER_CYCLE];
  logic last;
  assign last = col_cnt == LAST;
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    inv_mix_single_column u_col (
      .col(work[127 - 32 * (int'(col_cnt) + g) -: 32]),
      .res(col_res[g])
    );
  end
  // only the current column group is rewritten; the rest of the state passes through
  always_comb begin
    work_nx = work;
    for (int i = 0; i < COLS_PER_CYCLE; i++)
      work_nx[127 - 32 * (int'(col_cnt) + i) -: 32] = col_res[i];
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work <= '0;
      col_cnt <= '0;
      out_data <= '0;
    end else if (state == IDLE && in_valid) begin
      work <= in_data;
      col_cnt <= '0;
    end else if (state == BUSY) begin
      work <= work_nx;
      col_cnt <= col_cnt + STEP;
      if (last) out_data <= work_nx;
    end
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// tb_inv_mix_columns_iter: checks all three COLS_PER_CYCLE builds against a GF(2^8) matrix model
module tb_inv_mix_columns_iter;
  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;
  localparam logic [127:0] E2 = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
  localparam logic [127:0] ONES = {128{1'b1}};

  logic clk = 0;
  logic rst = 0;
  logic iv [3];
  logic [127:0] id [3];
  logic ordy [3];
  logic ir [3], ov [3], bz [3];
  logic [127:0] od [3];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [127:0] exq [3][$];
  int acq [3][$];
  logic pov [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : d
    inv_mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(iv[g]), .in_ready(ir[g]), .in_data(id[g]),
      .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(od[g]),
      .busy(bz[g])
    );
  end

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_mix(logic [127:0] s);
    logic [7:0] coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [127:0] r = 0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        logic [7:0] b = 0;
        for (int j = 0; j < 4; j++)
          b ^= gmul(s[127 - 32 * c - 8 * j -: 8], coef[(j - row + 4) % 4]);
        r[127 - 32 * c - 8 * row -: 8] = b;
      end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  // scoreboard: inputs and outputs are stable at the falling edge
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        exq[k].delete();
        acq[k].delete();
        pov[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        chk("ready_vs_busy", {127'b0, ir[k]}, {127'b0, !bz[k]});
        if (ov[k]) begin
          if (exq[k].size() == 0) chk("spurious_out_valid", 1, 0);
          else begin
            chk("sb_out_data", od[k], exq[k][0]);
            if (!pov[k]) chk("sb_latency", cyc - acq[k][0], (4 >> k) + 1);
            if (ordy[k]) begin
              void'(exq[k].pop_front());
              void'(acq[k].pop_front());
            end
          end
        end
        if (iv[k] && ir[k]) begin
          exq[k].push_back(inv_mix(id[k]));
          acq[k].push_back(cyc);
        end
        pov[k] = ov[k];
      end
    end
  end

  task automatic send(input int k, input logic [127:0] v);
    for (int t = 0; t < 20 && !ir[k]; t++) begin @(posedge clk); #1; end
    if (!ir[k]) chk("send_timeout", 0, 1);
    else begin
      id[k] = v;
      iv[k] = 1;
      @(posedge clk); #1;
      iv[k] = 0;
    end
  endtask

  task automatic wait_out(input int k);
    for (int t = 0; t < 20 && !ov[k]; t++) begin @(posedge clk); #1; end
    if (!ov[k]) chk("out_timeout", 0, 1);
  endtask

  task automatic run(input int k, input logic [127:0] v, input logic [127:0] e, input string nm);
    send(k, v);
    wait_out(k);
    chk(nm, od[k], e);
    @(posedge clk); #1;
  endtask

  task automatic b2b(input int k, input logic [127:0] a, input logic [127:0] b);
    int cnt = 0;
    for (int t = 0; t < 20 && !ir[k]; t++) begin @(posedge clk); #1; end
    id[k] = a;
    iv[k] = 1;
    @(posedge clk); #1;
    id[k] = b;
    while (!ir[k] && cnt < 20) begin @(posedge clk); #1; cnt++; end
    @(posedge clk); #1;
    cnt++;
    iv[k] = 0;
    chk("b2b_interval", cnt, (4 >> k) + 2);
    wait_out(k);
    chk("b2b_second", od[k], inv_mix(b));
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k] = 0; id[k] = 0; ordy[k] = 1; pov[k] = 0;
    end
    chk("pin_gmul", {120'b0, gmul(8'h57, 8'h13)}, {120'b0, 8'hfe});
    chk("pin_model_v1", inv_mix(V1), E1);
    chk("pin_model_v2", inv_mix(V2), E2);
    chk("pin_model_ff", inv_mix(ONES), ONES);
    #2 rst = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", {127'b0, ir[k]}, 1);
      chk("rst_out_valid", {127'b0, ov[k]}, 0);
      chk("rst_out_data", od[k], 0);
      chk("rst_busy", {127'b0, bz[k]}, 0);
    end
    @(negedge clk);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    run(0, V1, E1, "single_col_v1");
    for (int k = 0; k < 3; k++) run(k, V2, E2, "round_trip_v2");
    ordy[0] = 0;
    send(0, V2);
    wait_out(0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {127'b0, ov[0]}, 1);
      chk("bp_data", od[0], E2);
      chk("bp_in_ready", {127'b0, ir[0]}, 0);
      iv[0] = i == 3;
      id[0] = V1;
      @(posedge clk); #1;
    end
    iv[0] = 0;
    ordy[0] = 1;
    @(posedge clk); #1;
    chk("bp_release_valid", {127'b0, ov[0]}, 0);
    chk("bp_release_ready", {127'b0, ir[0]}, 1);
    for (int k = 0; k < 3; k++) b2b(k, V1, V2);
    send(0, V1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("midrst_out_valid", {127'b0, ov[0]}, 0);
    chk("midrst_out_data", od[0], 0);
    chk("midrst_in_ready", {127'b0, ir[0]}, 1);
    chk("midrst_busy", {127'b0, bz[0]}, 0);
    @(negedge clk);
    @(posedge clk); #1 rst = 0;
    run(0, V1, E1, "after_rst_v1");
    for (int i = 0; i < 1002; i++) begin
      logic [127:0] v;
      v = i == 0 ? 128'h0 : i == 1 ? ONES : {$urandom, $urandom, $urandom, $urandom};
      run(i % 3, v, i == 0 ? 128'h0 : i == 1 ? ONES : inv_mix(v), "random");
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("drain", exq[k].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
